// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO read port and sends them as 8N1/8E1 serial frames.
// Optional even-parity bit is compiled in with FIFO_UART_TX_PARITY_EN.
module fifo_uart_tx #(
  parameter int CLK_DIV   = 16,
  parameter int STOP_BITS = 1
) (
  input  logic       clk_i,
  input  logic       n_reset_i,
  input  logic       enable_i,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_data_i,
  output logic       fifo_rd_o,
  output logic       tx_o,
  output logic       busy_o
);
  localparam int BW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
  localparam logic [2:0] STOP_MAX = 3'(STOP_BITS - 1);
  typedef enum logic [2:0] {
    IDLE, POP, WAIT, START, DATA,
`ifdef FIFO_UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;
  state_t state, state_d;
  logic [BW-1:0] baud, baud_d, baud_nxt;
  logic [2:0] bit_cnt, bit_d;
  logic [7:0] shreg, shreg_d;
  logic baud_last, tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
  logic par;
`endif
  assign baud_last = baud == BAUD_MAX;
  assign baud_nxt = baud_last ? '0 : baud + 1'b1;
  always_comb begin
    state_d = state;
    baud_d = baud;
    bit_d = bit_cnt;
    shreg_d = shreg;
    case (state)
      IDLE: if (enable_i && !fifo_empty_i) state_d = POP;
      POP: state_d = WAIT;
      WAIT: begin
        shreg_d = fifo_data_i;
        baud_d = '0;
        bit_d = '0;
        state_d = START;
      end
      START: begin
        baud_d = baud_nxt;
        if (baud_last) state_d = DATA;
      end
      DATA: begin
        baud_d = baud_nxt;
        if (baud_last) begin
          shreg_d = shreg >> 1;
          bit_d = bit_cnt + 3'd1;
`ifdef FIFO_UART_TX_PARITY_EN
          if (bit_cnt == 3'd7) state_d = PARITY;
`else
          if (bit_cnt == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        baud_d = baud_nxt;
        if (baud_last) state_d = STOP;
      end
`endif
      STOP: begin
        baud_d = baud_nxt;
        if (baud_last) begin
          bit_d = bit_cnt == STOP_MAX ? 3'd0 : bit_cnt + 3'd1;
          if (bit_cnt == STOP_MAX) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs are registered from the next-state values so they line up with the state.
  always_comb begin
    tx_d = 1'b1;
    if (state_d == START) tx_d = 1'b0;
    if (state_d == DATA) tx_d = shreg_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
    if (state_d == PARITY) tx_d = par;
`endif
  end
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      shreg <= '0;
      fifo_rd_o <= 1'b0;
      tx_o <= 1'b1;
      busy_o <= 1'b0;
    end else begin
      state <= state_d;
      baud <= baud_d;
      bit_cnt <= bit_d;
      shreg <= shreg_d;
      fifo_rd_o <= state_d == POP;
      tx_o <= tx_d;
      busy_o <= state_d != IDLE;
    end
  end
`ifdef FIFO_UART_TX_PARITY_EN
  always_ff @(posedge clk_i or negedge n_reset_i) begin
    if (!n_reset_i) par <= 1'b0;
    else if (state == WAIT) par <= ^fifo_data_i;
  end
`endif
endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx: randomized and directed frame checks against a per-bit frame model and a queue FIFO.
module tb_fifo_uart_tx;
  localparam int DIV = 4;
  localparam int DIV2 = 1000;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 9 + P + 1;
  localparam int N = NB * DIV;
  localparam int NB2 = 9 + P + 2;

  logic clk = 0, n_reset = 0, enable = 0, fifo_empty = 1, empty2 = 1;
  logic [7:0] fifo_data = 8'h00;
  logic fifo_rd, tx, busy, rd2, tx2, busy2;
  int compared = 0, mismatched = 0, cyc = 0, pops = 0, bad_pops = 0, pops2 = 0, last_rd = 0;
  logic [7:0] q[$];
  logic [7:0] rb[6];
  logic [7:0] g[3];
  logic [7:0] r0, r1;

  fifo_uart_tx #(.CLK_DIV(DIV), .STOP_BITS(1)) dut (
    .clk_i(clk), .n_reset_i(n_reset), .enable_i(enable), .fifo_empty_i(fifo_empty),
    .fifo_data_i(fifo_data), .fifo_rd_o(fifo_rd), .tx_o(tx), .busy_o(busy));
  fifo_uart_tx #(.CLK_DIV(DIV2), .STOP_BITS(2)) dut2 (
    .clk_i(clk), .n_reset_i(n_reset), .enable_i(1'b1), .fifo_empty_i(empty2),
    .fifo_data_i(8'hFF), .fifo_rd_o(rd2), .tx_o(tx2), .busy_o(busy2));

  always #5 clk = ~clk;

  // Queue-backed FIFO: the entry is captured on the edge that ends the pop cycle.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd) begin
      if (q.size() == 0) bad_pops <= bad_pops + 1;
      else begin
        fifo_data <= q.pop_front();
        pops <= pops + 1;
      end
    end
    fifo_empty <= q.size() == 0;
    if (rd2) pops2 <= pops2 + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic push(input logic [7:0] b);
    q.push_back(b);
  endtask

  function automatic logic exp_bit(input logic [7:0] b, input int k, input int p);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && p == 1) return ^b;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    assert (got === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_rd(input int bound);
    for (int i = 0; i < bound && fifo_rd !== 1'b1; i++) @(negedge clk);
  endtask

  task automatic check_frame(input logic [7:0] b, input bit spaced, input bit drop);
    wait_rd(200);
    chk("pop_pulse", {31'd0, fifo_rd}, 1);
    chk("busy_with_pop", {31'd0, busy}, 1);
    if (spaced) chk("frame_spacing", cyc - last_rd, N + 3);
    last_rd = cyc;
    if (drop) enable = 0;
    @(negedge clk);
    chk("pop_single", {31'd0, fifo_rd}, 0);
    chk("wait_tx_high", {31'd0, tx}, 1);
    for (int k = 0; k < NB; k++)
      for (int c = 0; c < DIV; c++) begin
        @(negedge clk);
        chk($sformatf("tx_byte%0h_bit%0d", b, k), {31'd0, tx}, {31'd0, exp_bit(b, k, P)});
      end
    chk("busy_last_stop", {31'd0, busy}, 1);
    @(negedge clk);
    chk("idle_tx", {31'd0, tx}, 1);
    chk("idle_busy", {31'd0, busy}, 0);
  endtask

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 1);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_rd", {31'd0, fifo_rd}, 0);
    chk("reset_tx2", {31'd0, tx2}, 1);
    n_reset = 1;
    enable = 1;
    repeat (6) @(negedge clk);
    chk("no_pop_when_empty", pops, 0);

    push(8'hA5);
    check_frame(8'hA5, 0, 0);
    repeat (10) @(negedge clk);
    chk("single_pop_count", pops, 1);
    chk("single_idle_tx", {31'd0, tx}, 1);

    for (int i = 0; i < 8; i++) push(8'(i));
    for (int i = 0; i < 8; i++) check_frame(8'(i), i > 0, 0);
    repeat (20) @(negedge clk);
    chk("burst_pop_count", pops, 9);
    chk("burst_no_empty_pop", bad_pops, 0);

    for (int i = 0; i < 6; i++) begin
      rb[i] = 8'($urandom);
      push(rb[i]);
    end
    for (int i = 0; i < 6; i++) check_frame(rb[i], i > 0, 0);

    p0 = pops;
    for (int i = 0; i < 3; i++) begin
      g[i] = 8'($urandom);
      push(g[i]);
    end
    check_frame(g[0], 0, 0);
    check_frame(g[1], 1, 1);
    repeat (50) @(negedge clk);
    chk("gate_pop_count", pops - p0, 2);
    chk("gate_fifo_left", q.size(), 1);
    chk("gate_busy", {31'd0, busy}, 0);
    enable = 1;
    check_frame(g[2], 0, 0);

    r0 = 8'($urandom);
    r1 = 8'($urandom);
    push(r0);
    push(r1);
    wait_rd(200);
    chk("rst_pop", {31'd0, fifo_rd}, 1);
    repeat (2 + 4 * DIV + 1) @(negedge clk);
    chk("rst_pre_bit3", {31'd0, tx}, {31'd0, r0[3]});
    n_reset = 0;
    #1;
    chk("rst_tx", {31'd0, tx}, 1);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_rd", {31'd0, fifo_rd}, 0);
    @(negedge clk);
    n_reset = 1;
    check_frame(r1, 0, 0);
    chk("rst_fifo_drained", q.size(), 0);
    chk("total_no_empty_pop", bad_pops, 0);

    empty2 = 0;
    for (int i = 0; i < 20 && rd2 !== 1'b1; i++) @(negedge clk);
    chk("d2_pop", {31'd0, rd2}, 1);
    @(negedge clk);
    empty2 = 1;
    for (int k = 0; k < NB2; k++)
      for (int c = 0; c < DIV2; c++) begin
        @(negedge clk);
        if (c == 0 || c == DIV2 - 1)
          chk($sformatf("d2_bit%0d_c%0d", k, c), {31'd0, tx2}, {31'd0, exp_bit(8'hFF, k, P)});
      end
    chk("d2_busy_last", {31'd0, busy2}, 1);
    @(negedge clk);
    chk("d2_idle_busy", {31'd0, busy2}, 0);
    chk("d2_idle_tx", {31'd0, tx2}, 1);
    chk("d2_pops", pops2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
